seq_recognizer_param: RTL and testbench

Programmable serial sequence recognizer, the parametrised successor to the fixed-pattern recognizer FSM. It compares a gated serial bit stream against a run-time loaded pattern of 1..PAT_W bits and pulses `z` on every match. Overlapping or non-overlapping detection is selectable, and an optional lock mode traps the block after the first match. It keeps a saturating match counter and sits directly on the serial input path of the lab top level.

---
 rtl/seq_rec_pkg.sv | 18 +
 rtl/seq_match_cmp.sv | 24 ++
 rtl/seq_recognizer_param.sv | 139 +++++++++++++
 tb/tb_seq_recognizer_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_rec_pkg.sv
// Shared types and constants for the programmable serial sequence recognizer.
package seq_rec_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StRun    = 2'd1;
    localparam state_t StLocked = 2'd2;

    // Width needed to hold a length in 0..pat_w.
    function automatic int unsigned len_w(input int unsigned pat_w);
        return int'($clog2(pat_w + 1));
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare of the low len bits of the history against the pattern.
module seq_match_cmp #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] fill,
    output logic             hit
);

    logic [PAT_W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
    end

    assign hit = (len != '0) && (fill >= len) && (((hist ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_recognizer_param.sv
// Programmable serial sequence recognizer with overlap/lock modes and a
// saturating match counter.
module seq_recognizer_param
    import seq_rec_pkg::*;
#(
    parameter int unsigned  PAT_W = PAT_W_DEF,
    parameter int unsigned  CNT_W = CNT_W_DEF,
    localparam int unsigned LEN_W = len_w(PAT_W)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cfg_lock,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             locked,
    output logic             cfg_err
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [LEN_W-1:0] fill_q, fill_d, len_q, len_d;
    logic             ovl_q, ovl_d, lock_q, lock_d;
    logic             z_q, z_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             hit, accept, len_ok;

    assign hist_shift = {hist_q[PAT_W-2:0], x};
    assign fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    assign cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign accept     = (state_q == StRun) && x_valid;
    assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

    // Match is judged on the post-shift history and fill.
    seq_match_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist (hist_shift),
        .pat  (pat_q),
        .len  (len_q),
        .fill (fill_inc),
        .hit  (hit)
    );

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        z_d     = 1'b0;
        err_d   = 1'b0;

        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            if (len_ok) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                lock_d  = cfg_lock;
                state_d = StRun;
            end else begin
                // A rejected load leaves the block unconfigured, as after reset.
                pat_d   = '0;
                len_d   = '0;
                ovl_d   = 1'b0;
                lock_d  = 1'b0;
                state_d = StIdle;
                err_d   = 1'b1;
            end
        end else if (clear && (state_q != StIdle)) begin
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            state_d = StRun;
        end else if (accept) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (hit) begin
                z_d   = 1'b1;
                cnt_d = cnt_sat;
                if (!ovl_q) begin
                    fill_d = '0;
                end
                if (lock_q) begin
                    state_d = StLocked;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign locked      = (state_q == StLocked);
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_recognizer_param.sv
// Randomized and directed bench for seq_recognizer_param against a queue-based model.
module tb_seq_recognizer_param;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LEN_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             x = 1'b0, x_valid = 1'b0, cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0, cfg_lock = 1'b0, clear = 1'b0;
    logic             z, locked, cfg_err;
    logic [CNT_W-1:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the accepted bits since the last restart, newest at the back.
    bit               m_cfg, m_lk, m_ovl, m_lock;
    bit               q[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len, m_cnt;
    bit               e_z, e_err;

    seq_recognizer_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_lock    (cfg_lock),
        .clear       (clear),
        .z           (z),
        .match_count (match_count),
        .locked      (locked),
        .cfg_err     (cfg_err)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cfg = 0; m_lk = 0; m_ovl = 0; m_lock = 0;
        m_pat = '0; m_len = 0; m_cnt = 0; e_z = 0; e_err = 0;
        q.delete();
    endtask

    task automatic model_edge();
        bit ok;
        e_z = 0;
        e_err = 0;
        if (cfg_load) begin
            q.delete();
            m_cnt = 0;
            m_lk  = 0;
            if (cfg_len >= 1 && cfg_len <= PAT_W) begin
                m_cfg = 1; m_pat = cfg_pattern; m_len = int'(cfg_len);
                m_ovl = cfg_overlap; m_lock = cfg_lock;
            end else begin
                m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_lock = 0;
                e_err = 1;
            end
        end else if (clear && m_cfg) begin
            q.delete();
            m_cnt = 0;
            m_lk  = 0;
        end else if (m_cfg && !m_lk && x_valid) begin
            q.push_back(x);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (q.size() >= m_len) begin
                ok = 1;
                // Oldest bit of the window must equal pattern bit len-1.
                for (int i = 0; i < m_len; i++) begin
                    if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) ok = 0;
                end
                if (ok) begin
                    e_z = 1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    if (!m_ovl) q.delete();
                    if (m_lock) m_lk = 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".z"}, z, e_z);
        check_val({tag, ".cnt"}, match_count, m_cnt);
        check_val({tag, ".locked"}, locked, m_cfg && m_lk);
        check_val({tag, ".err"}, cfg_err, e_err);
    endtask

    task automatic step(input bit bx, input bit bv, input bit ld, input bit clr,
                        input string tag);
        @(negedge clock);
        x = bx; x_valid = bv; cfg_load = ld; clear = clr;
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input int len, input bit ovl, input bit lk,
                        input bit bx, input bit bv);
        @(negedge clock);
        cfg_pattern = p; cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_lock = lk;
        x = bx; x_valid = bv; cfg_load = 1; clear = 0;
        @(posedge clock);
        model_edge();
        #1;
        compare_all("load");
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1, 0, 0, tag);
    endtask

    initial begin
        model_reset();
        #12;
        reset = 1'b1;
        #1;
        compare_all("reset");

        // Reset mid-stream, then confirm stream is ignored until a new load.
        load(8'b1011, 4, 1, 0, 0, 0);
        feed(16'b101, 3, "pre_rst");
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "idle_stream");

        // Overlapping: 1011011 -> matches after bits 4 and 7.
        load(8'b1011, 4, 1, 0, 0, 0);
        feed(16'b1011011, 7, "ovl");
        check_val("ovl_total", match_count, 2);

        // Non-overlapping: one match, then 1011 gives the second.
        load(8'b1011, 4, 0, 0, 0, 0);
        feed(16'b1011011, 7, "novl");
        check_val("novl_total1", match_count, 1);
        feed(16'b1011, 4, "novl2");
        check_val("novl_total2", match_count, 2);

        // Lock mode, then clear and re-detect.
        load(8'b1011, 4, 1, 1, 0, 0);
        feed(16'b10111011, 8, "lock");
        check_val("lock_locked", locked, 1);
        check_val("lock_total", match_count, 1);
        step(0, 0, 0, 1, "lock_clr");
        check_val("clr_locked", locked, 0);
        feed(16'b1011, 4, "after_clr");
        check_val("after_clr_total", match_count, 1);

        // Saturation with gating.
        load(8'b1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, "sat_on");
            step(1, 0, 0, 0, "sat_gap");
        end
        check_val("sat_total", match_count, 15);

        // Full-length overlapping pattern at the fill boundary.
        load(8'hAA, 8, 1, 0, 0, 0);
        feed(16'hAAAA, 16, "full");

        // Invalid lengths.
        load(8'hFF, 9, 1, 0, 0, 0);
        check_val("inv9_err", cfg_err, 1);
        step(1, 1, 0, 0, "inv9_after");
        check_val("inv9_err_gone", cfg_err, 0);
        load(8'hFF, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, "inv0_after");

        // Load or clear on the completing edge suppresses the match.
        load(8'b1011, 4, 1, 0, 0, 0);
        feed(16'b101, 3, "sim_ld");
        load(8'b1011, 4, 1, 0, 1, 1);
        check_val("sim_ld_z", z, 0);
        feed(16'b101, 3, "sim_clr");
        step(1, 1, 0, 1, "sim_clr_edge");
        check_val("sim_clr_z", z, 0);

        // Randomized stream with occasional reconfiguration and clears.
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                load(PAT_W'($urandom), $urandom_range(0, 9), 1'($urandom),
                     ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
            end else if (r < 4) begin
                step(1'($urandom), 1'($urandom), 0, 1, "rnd_clr");
            end else begin
                step(1'($urandom), ($urandom_range(0, 9) < 7), 0, 0, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
